// File: rtl/npu_pkg.sv
// npu_pkg: types, constants and arithmetic helpers shared by the NPU GEMM datapath.
package npu_pkg;

   // Accumulator buffer controller states.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } acc_buf_state_t;

   // Cycles from acc_rd_en to acc_rd_valid.
   localparam int unsigned ACC_BUF_RD_LAT = 1;

   // Signed 32-bit add that clamps to the representable range instead of wrapping.
   function automatic logic signed [31:0] sat_add_i32(input logic signed [31:0] a,
                                                      input logic signed [31:0] b);
      logic [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31]) begin
         sat_add_i32 = s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      end else begin
         sat_add_i32 = s[31:0];
      end
   endfunction

endpackage

// File: rtl/gemm_acc_mem.sv
// gemm_acc_mem: DEPTH x WIDTH accumulator storage. One write port and two
// synchronous read ports (A: post-processing reads, B: read-modify-write
// fetch). Both read ports are write-first against the same-cycle write.
// No reset on the array so the block maps onto an SRAM macro.
module gemm_acc_mem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_ra_addr,
   output logic [WIDTH-1:0] o_ra_data,
   input  logic [AW-1:0]    i_rb_addr,
   output logic [WIDTH-1:0] o_rb_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_ra_data;
   logic [WIDTH-1:0] r_rb_data;

   // Array write.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered reads; a same-address write in this cycle is returned directly.
   always_ff @(posedge clk) begin
      r_ra_data <= (i_we && (i_waddr == i_ra_addr)) ? i_wdata : r_mem[i_ra_addr];
      r_rb_data <= (i_we && (i_waddr == i_rb_addr)) ? i_wdata : r_mem[i_rb_addr];
   end

   assign o_ra_data = r_ra_data;
   assign o_rb_data = r_rb_data;

endmodule

// File: rtl/gemm_acc_buf.sv
// gemm_acc_buf: accumulator buffer for the GEMM datapath. Accepts drain
// writes (overwrite or read-modify-write accumulate) through a 2-stage
// pipeline with W1->W0 forwarding, serves 1-cycle reads to post-processing,
// and sweeps all entries to zero on a clear command.
// Build option: define GEMM_ACC_SAT_EN to saturate the accumulate add
// (uses npu_pkg::sat_add_i32, so ACC_W must be 32); otherwise it wraps.
module gemm_acc_buf
   import npu_pkg::*;
#(
   parameter int unsigned ARRAY_M = 16,
   parameter int unsigned ARRAY_N = 16,
   parameter int unsigned ACC_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_valid,
   output logic             clr_ready,
   input  logic             wr_en,
   input  logic [15:0]      wr_addr,
   input  logic [ACC_W-1:0] wr_data,
   input  logic             wr_accum,
   input  logic             acc_rd_en,
   input  logic [15:0]      acc_rd_addr,
   output logic [ACC_W-1:0] acc_rd_data,
   output logic             acc_rd_valid,
   output logic             busy,
   output logic             err
);

   localparam int unsigned   DEPTH    = ARRAY_M * ARRAY_N;
   localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [15:0]   DEPTH16  = 16'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   acc_buf_state_t r_state;
   acc_buf_state_t w_state_nxt;
   logic [AW-1:0]  r_clr_ptr;
   logic           w_clr_accept;
   logic           w_in_clear;

   logic           w_wr_in_range;
   logic           w_rd_in_range;
   logic           w_wr_take;

   logic             r_w0_vld;
   logic [AW-1:0]    r_w0_addr;
   logic [ACC_W-1:0] r_w0_data;
   logic             r_w0_accum;

   logic             r_w1_vld;
   logic [AW-1:0]    r_w1_addr;
   logic [ACC_W-1:0] r_w1_data;
   logic             r_w1_accum;
   logic [ACC_W-1:0] r_w1_base;

   logic [ACC_W-1:0] w_w0_base;
   logic [ACC_W-1:0] w_w1_result;

   logic             w_mem_we;
   logic [AW-1:0]    w_mem_waddr;
   logic [ACC_W-1:0] w_mem_wdata;
   logic [ACC_W-1:0] w_mem_ra;
   logic [ACC_W-1:0] w_mem_rb;

   logic [ACC_BUF_RD_LAT-1:0] r_rd_valid;
   logic                      r_rd_pass;
   logic                      r_err;

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and clear handshake.
   always_comb begin
      w_state_nxt  = r_state;
      clr_ready    = 1'b0;
      w_clr_accept = 1'b0;
      w_in_clear   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            clr_ready = 1'b1;
            if (clr_valid) begin
               w_clr_accept = 1'b1;
               w_state_nxt  = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_in_clear = 1'b1;
            if (r_clr_ptr == LAST_PTR) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Sweep pointer: restarts at 0 on accept, advances one entry per CLEAR cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_ptr <= '0;
      end else if (w_clr_accept) begin
         r_clr_ptr <= '0;
      end else if (w_in_clear) begin
         r_clr_ptr <= r_clr_ptr + AW'(1);
      end
   end

   assign w_wr_in_range = (wr_addr < DEPTH16);
   assign w_rd_in_range = (acc_rd_addr < DEPTH16);
   assign w_wr_take     = wr_en && w_wr_in_range && !w_in_clear;

   // W0: capture the beat; its memory fetch is issued in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w0_vld   <= 1'b0;
         r_w0_addr  <= '0;
         r_w0_data  <= '0;
         r_w0_accum <= 1'b0;
      end else begin
         r_w0_vld <= w_wr_take;
         if (w_wr_take) begin
            r_w0_addr  <= wr_addr[AW-1:0];
            r_w0_data  <= wr_data;
            r_w0_accum <= wr_accum;
         end
      end
   end

   // The fetch for W0 was issued before W1's beat committed, so a matching
   // W1 supplies the base; older writes are already covered by write-first.
   assign w_w0_base = (r_w1_vld && (r_w1_addr == r_w0_addr)) ? w_w1_result : w_mem_rb;

   // W1: hold the beat together with its resolved base value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w1_vld   <= 1'b0;
         r_w1_addr  <= '0;
         r_w1_data  <= '0;
         r_w1_accum <= 1'b0;
         r_w1_base  <= '0;
      end else begin
         r_w1_vld <= r_w0_vld;
         if (r_w0_vld) begin
            r_w1_addr  <= r_w0_addr;
            r_w1_data  <= r_w0_data;
            r_w1_accum <= r_w0_accum;
            r_w1_base  <= w_w0_base;
         end
      end
   end

   // New entry value: overwrite or signed accumulate.
   always_comb begin
      w_w1_result = r_w1_data;
      if (r_w1_accum) begin
`ifdef GEMM_ACC_SAT_EN
         w_w1_result = sat_add_i32(r_w1_base, r_w1_data);
`else
         w_w1_result = r_w1_base + r_w1_data;
`endif
      end
   end

   // Write port: the sweep owns it during CLEAR; W1 beats in CLEAR are dropped
   // since the sweep zeroes every entry anyway.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_waddr = r_w1_addr;
      w_mem_wdata = w_w1_result;
      if (w_in_clear) begin
         w_mem_we    = 1'b1;
         w_mem_waddr = r_clr_ptr;
         w_mem_wdata = '0;
      end else if (r_w1_vld) begin
         w_mem_we = 1'b1;
      end
   end

   gemm_acc_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ACC_W),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .i_we      (w_mem_we),
      .i_waddr   (w_mem_waddr),
      .i_wdata   (w_mem_wdata),
      .i_ra_addr (acc_rd_addr[AW-1:0]),
      .o_ra_data (w_mem_ra),
      .i_rb_addr (wr_addr[AW-1:0]),
      .o_rb_data (w_mem_rb)
   );

   // Read response strobe, zero-data qualifier and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= '0;
         r_rd_pass  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_rd_valid <= acc_rd_en;
         r_rd_pass  <= acc_rd_en && w_rd_in_range && !w_in_clear;
         r_err      <= (wr_en && (w_in_clear || !w_wr_in_range)) ||
                       (acc_rd_en && !w_rd_in_range);
      end
   end

   assign acc_rd_valid = r_rd_valid[ACC_BUF_RD_LAT-1];
   assign acc_rd_data  = r_rd_pass ? w_mem_ra : '0;
   assign busy         = w_in_clear || r_w0_vld || r_w1_vld;
   assign err          = r_err;

endmodule

// File: tb/tb_gemm_acc_buf.sv
// tb_gemm_acc_buf: scoreboard bench for gemm_acc_buf. The stimulus side keeps
// an array model of the accumulators (writes become visible to reads issued
// two cycles later, clears zero everything) and queues expected responses;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_gemm_acc_buf;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr_valid = 1'b0;
   logic        clr_ready;
   logic        wr_en = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_accum = 1'b0;
   logic        acc_rd_en = 1'b0;
   logic [15:0] acc_rd_addr = '0;
   logic [31:0] acc_rd_data;
   logic        acc_rd_valid;
   logic        busy;
   logic        err;

   gemm_acc_buf #(.ARRAY_M(16), .ARRAY_N(16), .ACC_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_valid    (clr_valid),
      .clr_ready    (clr_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_accum     (wr_accum),
      .acc_rd_en    (acc_rd_en),
      .acc_rd_addr  (acc_rd_addr),
      .acc_rd_data  (acc_rd_data),
      .acc_rd_valid (acc_rd_valid),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      int          addr;
      logic [31:0] data;
      logic        accum;
   } wr_t;

   typedef struct {
      int          c;
      int          addr;
      logic [31:0] data;
   } rd_t;

   wr_t         pend_q[$];
   rd_t         rd_q[$];
   int          err_q[$];
   logic [31:0] ref_mem [DEPTH];
   int          clr_t = -100000;
   int          checks = 0;
   int          errors = 0;

   function automatic bit in_clear(input int c);
      return (c > clr_t) && (c <= clr_t + DEPTH);
   endfunction

   function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef GEMM_ACC_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return s[31:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic apply_pending(input int c);
      wr_t w;
      while (pend_q.size() > 0 && pend_q[0].c <= c - 2) begin
         w = pend_q.pop_front();
         ref_mem[w.addr] = w.accum ? acc_add(ref_mem[w.addr], w.data) : w.data;
      end
   endtask

   // One clock of stimulus; updates the model and queues expectations.
   task automatic step(input logic we, input int wa, input logic [31:0] wd, input logic wacc,
                       input logic re, input int ra, input logic clr);
      bit e;
      @(posedge clk);
      #1;
      apply_pending(cyc);
      check("clr_ready", 32'(clr_ready), 32'(!in_clear(cyc)));
      if (in_clear(cyc)) check("busy_clear", 32'(busy), 32'd1);
      e = 1'b0;
      if (re) begin
         rd_q.push_back('{c: cyc, addr: ra,
                          data: (in_clear(cyc) || ra >= DEPTH) ? 32'd0 : ref_mem[ra]});
         if (ra >= DEPTH) e = 1'b1;
      end
      if (we) begin
         if (in_clear(cyc) || wa >= DEPTH) e = 1'b1;
         else pend_q.push_back('{c: cyc, addr: wa, data: wd, accum: wacc});
      end
      if (clr && !in_clear(cyc)) begin
         while (pend_q.size() > 0 && pend_q[pend_q.size()-1].c >= cyc - 1)
            void'(pend_q.pop_back());
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         clr_t = cyc;
      end
      if (e) err_q.push_back(cyc + 1);
      wr_en       = we;
      wr_addr     = 16'(wa);
      wr_data     = wd;
      wr_accum    = wacc;
      acc_rd_en   = re;
      acc_rd_addr = 16'(ra);
      clr_valid   = clr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_clr_ready"}, 32'(clr_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_rd_valid"}, 32'(acc_rd_valid), 32'd0);
      check({tag, "_rd_data"}, acc_rd_data, 32'd0);
   endtask

   task automatic clear_and_measure(input string tag);
      int lo;
      lo = 0;
      step(1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         step(1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
         if (clr_ready === 1'b0) lo++;
         else break;
      end
      check({tag, "_clear_cycles"}, 32'(lo), 32'd256);
   endtask

   // Monitor: compare every presented response against the scoreboard.
   rd_t  mon_r;
   logic mon_exp_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (acc_rd_valid) begin
               if (rd_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rd_unexpected: got valid=1 want no response (cycle %0d)", cyc);
               end else begin
                  mon_r = rd_q.pop_front();
                  check($sformatf("rd_data[%0d]", mon_r.addr), acc_rd_data, mon_r.data);
                  check("rd_latency", 32'(cyc), 32'(mon_r.c + 1));
               end
            end
            mon_exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
            if (mon_exp_e) void'(err_q.pop_front());
            if (err || mon_exp_e) check("err", 32'(err), 32'(mon_exp_e));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic we, wacc, re, clr;
      int wa, ra;
      logic [31:0] wd;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_outputs("rst0");

      // Clear, then read back every entry.
      clear_and_measure("clr0");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 32'd0, 1'b0, 1'b1, i, 1'b0);
      idle(2);

      // Overwrite then back-to-back accumulates on one address.
      step(1'b1, 5, 32'd100, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 5, 32'd7, 1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 5, 32'hFFFF_FFFD, 1'b1, 1'b0, 0, 1'b0);
      step(1'b0, 0, 32'd0, 1'b0, 1'b1, 5, 1'b0);
      step(1'b0, 0, 32'd0, 1'b0, 1'b1, 5, 1'b0);
      idle(2);

      // Accumulate across the positive overflow boundary.
      step(1'b1, 10, 32'h7FFF_FFF0, 1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 10, 32'h0000_0020, 1'b1, 1'b0, 0, 1'b0);
      idle(2);
      step(1'b0, 0, 32'd0, 1'b0, 1'b1, 10, 1'b0);
      idle(2);

      // Out-of-range write and read; the aliased in-range entry must not change.
      step(1'b1, 44, 32'h0000_ABCD, 1'b0, 1'b0, 0, 1'b0);
      idle(2);
      step(1'b1, 300, 32'd123, 1'b0, 1'b1, 256, 1'b0);
      idle(2);
      step(1'b0, 0, 32'd0, 1'b0, 1'b1, 44, 1'b0);
      idle(2);

      // Writes around and during a clear are dropped; reads during clear give 0.
      step(1'b1, 77, 32'd999, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 3, 32'd11, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 3, 32'd12, 1'b1, 1'b1, 77, 1'b1);
      for (int i = 0; i < DEPTH; i++)
         step(i == 50 || i == 255, 77, 32'd55, 1'b0, i == 60 || i == 200, (i == 200) ? 300 : 77, 1'b0);
      step(1'b0, 0, 32'd0, 1'b0, 1'b1, 77, 1'b0);
      step(1'b0, 0, 32'd0, 1'b0, 1'b1, 3, 1'b0);
      idle(2);

      // Randomized traffic concentrated on a few addresses to stress forwarding.
      for (int i = 0; i < 3000; i++) begin
         we   = ($urandom_range(0, 99) < 60);
         wa   = ($urandom_range(0, 29) == 0) ? int'($urandom_range(256, 65535)) : int'($urandom_range(0, 15));
         wd   = $urandom;
         if ($urandom_range(0, 7) == 0) wd = {wd[31], {6{~wd[31]}}, wd[24:0]};
         wacc = ($urandom_range(0, 2) != 0);
         re   = ($urandom_range(0, 99) < 50);
         ra   = ($urandom_range(0, 29) == 0) ? int'($urandom_range(256, 65535))
              : ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
         clr  = ($urandom_range(0, 999) == 0);
         step(we, wa, wd, wacc, re, ra, clr);
      end
      idle(300);

      // Reset in the middle of a sweep, then reissue the clear.
      step(1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
      idle(100);
      @(posedge clk);
      #1;
      check("busy_mid_clear", 32'(busy), 32'd1);
      rst_n = 1'b0;
      clr_valid = 1'b0; wr_en = 1'b0; acc_rd_en = 1'b0;
      rd_q.delete(); err_q.delete(); pend_q.delete();
      clr_t = -100000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_outputs("rst1");
      clear_and_measure("clr1");
      for (int i = 0; i < 16; i++) step(1'b0, 0, 32'd0, 1'b0, 1'b1, i * 17, 1'b0);
      idle(4);

      check("rd_drain", 32'(rd_q.size()), 32'd0);
      check("err_drain", 32'(err_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gemm_acc_buf.md
Name: gemm_acc_buf

Overview:
- Accumulator SRAM responder for the GEMM datapath. It holds ARRAY_M*ARRAY_N signed ACC_W accumulators.
- Write side: the systolic-array drain, with overwrite or accumulate (read-modify-write) per beat.
- Read side: the post-processing engine, using the acc_rd_en/acc_rd_addr request and acc_rd_data/acc_rd_valid response.
- A clear command sweeps all entries to zero before a new tile.

Parameters:
- ARRAY_M, 16, systolic rows
- ARRAY_N, 16, systolic columns
- ACC_W, 32, accumulator width in bits
- DEPTH, ARRAY_M*ARRAY_N, number of entries (localparam, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clr_valid  in  1  clear request
- clr_ready  out  1  clear accepted when high with clr_valid
- wr_en  in  1  drain write beat
- wr_addr  in  16  entry index
- wr_data  in  ACC_W  signed partial sum
- wr_accum  in  1  1 = mem+wr_data, 0 = overwrite
- acc_rd_en  in  1  read request
- acc_rd_addr  in  16  entry index
- acc_rd_data  out  ACC_W  signed read data
- acc_rd_valid  out  1  read response strobe
- busy  out  1  clear in progress or write pipeline occupied
- err  out  1  one-cycle pulse: out-of-range access or write dropped during clear

Behaviour:
- Reset values: all outputs 0, except clr_ready, which is 1 in IDLE after reset. Pipeline valids clear. Memory contents are not reset.
- Reset mid-clear aborts the sweep. Contents are then undefined and the clear must be reissued.
- FSM states are ST_IDLE and ST_CLEAR.
- IDLE → CLEAR on clr_valid && clr_ready. clr_ready = (state==ST_IDLE).
- CLEAR writes 0 to clr_ptr, one entry per cycle, from 0 to DEPTH-1. After writing DEPTH-1 it returns to IDLE, so CLEAR lasts exactly DEPTH cycles.
- A W1 write pending in the clear-accept cycle commits in that cycle. The sweep overwrites it later.
- Write pipeline, 2 stages:
  - W0 registers wr_addr/wr_data/wr_accum and reads mem[wr_addr].
  - W1 computes the new value and writes it.
- Forwarding: if W0 addr == W1 addr, W1's result replaces the memory read. Back-to-back accumulates to the same address must never lose an update. Full throughput is one write per cycle.
- Overwrite (wr_accum=0) does not use the read value.
- Read latency is exactly 1 cycle: acc_rd_valid=1 the cycle after acc_rd_en, with acc_rd_data registered.
- Read-during-write to the same address is write-first: the value committed by W1 in the request cycle is returned.
- A read in CLEAR returns 0 with valid=1.
- Out-of-range (addr >= DEPTH):
  - Write is dropped, with an err pulse in the W0 cycle.
  - Read returns 0 with valid=1, plus an err pulse.
- wr_en in ST_CLEAR: the beat is dropped, with an err pulse. Reads are unaffected.
- Read and write ports are independent. Simultaneous read, write and clear-accept in one cycle are all legal.
- busy = (state==ST_CLEAR) || W0 valid || W1 valid.
- Arithmetic: signed ACC_W add. The result is the same width; overflow handling depends on the optional feature.

Optional Feature:
- Macro: GEMM_ACC_SAT_EN.
- Defined: the accumulate add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] using the package sat_add_i32.
- Undefined: the add wraps modulo 2^ACC_W. There is no overflow detection.
- Overwrite mode behaves identically in both builds.

Decomposition:
- npu_pkg gets:
  - acc_buf_state_t enum {ST_IDLE, ST_CLEAR}
  - an ACC_BUF_RD_LAT=1 constant
  - reuse of sat_add_i32
- One natural sub-module: gemm_acc_mem. It is a simple dual-port RAM (1 sync read + 1 write, write-first, plus a second read port for W0), DEPTH x ACC_W. The wrapper keeps the FSM, pipeline, forwarding and range checks, so gemm_acc_mem can later be swapped for an SRAM macro.

Test Plan:
- Clear, then read all 256 entries → 256 responses, each valid one cycle after its request, all data 0. CLEAR lasts exactly 256 cycles with busy=1 and clr_ready=0.
- Overwrite addr 5 = 100, then accumulate addr 5 with +7, +(-3) on consecutive cycles, then read addr 5 → 104 (forwarding check).
- Accumulate addr 10 with 0x7FFFFFF0 then +0x20 → with GEMM_ACC_SAT_EN the read gives 0x7FFFFFFF; without it, 0x80000010.
- Write addr 300 and read addr 256 → err pulses, write dropped, read data 0 with valid. A subsequent read of addr 44 (300 mod 256) is unchanged.
- wr_en during CLEAR → err pulse, beat dropped. After clear, the entry reads 0.
- Assert rst_n low at sweep entry 100 → all outputs 0 and clr_ready=1 after release. A reissued clear then completes in 256 cycles.
